window_trap_controller: RTL and testbench

Sequencer that owns the register-window state: current window pointer, window invalid mask, ET, S and PS. It sits between the control unit and the register file. It accepts SAVE, RESTORE, RETT and WRWIM operations over a valid/ready handshake and tests each move against the WIM. It either commits the window change or runs the trap-entry sequence (overflow/underflow/illegal) with a request/acknowledge handshake to the trap vector logic.

---
 rtl/window_trap_controller.sv | 135 +++++++++++++
 tb/tb_window_trap_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/window_trap_controller.sv
// Register-window sequencer: CWP/WIM/ET/S/PS ownership, WIM-checked window
// moves and trap-entry handshake toward the trap vector logic.
module window_trap_controller #(
  parameter int NWINDOWS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] wr_data,
  output logic        op_ready,
  output logic        done,
  output logic        trap_req,
  output logic [7:0]  tt,
  input  logic        trap_ack,
  output logic        error,
  output logic [4:0]  cwp,
  output logic [31:0] wim,
  output logic        et,
  output logic        s,
  output logic        ps
);

  typedef enum logic [1:0] {
    IDLE, EVAL, TRAP, ERR
  } state_t;

  localparam logic [63:0] M64 =
    (64'd1 << NWINDOWS) - 64'd1;
  localparam logic [31:0] WMASK = M64[31:0];
  localparam logic [4:0] WTOP = 5'(NWINDOWS - 1);

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] wr_q;

  logic        is_save, is_rest, is_rett, is_wrwim;
  logic [4:0]  cwp_dec, cwp_inc, tgt;
  logic [7:0]  code;
  logic        trap_c;

  assign is_save  = (op_q == 2'b00);
  assign is_rest  = (op_q == 2'b01);
  assign is_rett  = (op_q == 2'b10);
  assign is_wrwim = (op_q == 2'b11);

  assign cwp_dec = (cwp == 5'd0) ? WTOP : cwp - 5'd1;
  assign cwp_inc = (cwp == WTOP) ? 5'd0 : cwp + 5'd1;

  // RETT with traps enabled is illegal before any WIM test
  always_comb begin
    tgt    = cwp_inc;
    code   = 8'h06;
    trap_c = 1'b0;
    unique case (1'b1)
      is_save: begin
        tgt    = cwp_dec;
        code   = 8'h05;
        trap_c = wim[cwp_dec];
      end
      is_rest: trap_c = wim[cwp_inc];
      is_rett: begin
        code   = et ? 8'h02 : 8'h06;
        trap_c = et | wim[cwp_inc];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= 2'b00;
      wr_q     <= 32'h0;
      op_ready <= 1'b1;
      done     <= 1'b0;
      trap_req <= 1'b0;
      tt       <= 8'h00;
      error    <= 1'b0;
      cwp      <= 5'd0;
      wim      <= 32'h0;
      et       <= 1'b0;
      s        <= 1'b1;
      ps       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_q     <= op;
            wr_q     <= wr_data & WMASK;
            op_ready <= 1'b0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          if (!trap_c) begin
            if (is_wrwim) wim <= wr_q;
            else          cwp <= tgt;
            if (is_rett) begin
              et <= 1'b1;
              s  <= ps;
            end
            done     <= 1'b1;
            op_ready <= 1'b1;
            state    <= IDLE;
          end else if (et) begin
            tt       <= code;
            trap_req <= 1'b1;
            state    <= TRAP;
          end else begin
            error <= 1'b1;
            state <= ERR;
          end
        end
        TRAP: begin
          if (trap_ack) begin
            et       <= 1'b0;
            ps       <= s;
            s        <= 1'b1;
            cwp      <= cwp_dec;
            trap_req <= 1'b0;
            tt       <= 8'h00;
            done     <= 1'b1;
            op_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        ERR: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_trap_controller.sv
// Directed bench for window_trap_controller with NWINDOWS=4.
// Hand-computed expectations checked with immediate assertions.
module tb_window_trap_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] wr_data;
  logic        op_ready, done, trap_req;
  logic [7:0]  tt;
  logic        trap_ack, error;
  logic [4:0]  cwp;
  logic [31:0] wim;
  logic        et, s, ps;

  int checks = 0;
  int errors = 0;

  window_trap_controller #(.NWINDOWS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .op       (op),
    .wr_data  (wr_data),
    .op_ready (op_ready),
    .done     (done),
    .trap_req (trap_req),
    .tt       (tt),
    .trap_ack (trap_ack),
    .error    (error),
    .cwp      (cwp),
    .wim      (wim),
    .et       (et),
    .s        (s),
    .ps       (ps)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // accept edge then eval edge; returns 1ns after the eval edge
  task automatic do_op(input logic [1:0] o,
                       input logic [31:0] d);
    op_valid = 1'b1;
    op       = o;
    wr_data  = d;
    tick();
    op_valid = 1'b0;
    wr_data  = 32'h0;
    tick();
  endtask

  initial begin
    reset_n  = 1'b0;
    op_valid = 1'b0;
    op       = 2'b00;
    wr_data  = 32'h0;
    trap_ack = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_cwp", 32'(cwp), 0);
    chk("rst_wim", wim, 0);
    chk("rst_et", 32'(et), 0);
    chk("rst_s", 32'(s), 1);
    chk("rst_ps", 32'(ps), 0);
    chk("rst_ready", 32'(op_ready), 1);
    chk("rst_treq", 32'(trap_req), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_tt", 32'(tt), 0);

    // WRWIM masking
    op_valid = 1'b1; op = 2'b11; wr_data = 32'h0000_00F1;
    tick();
    op_valid = 1'b0;
    chk("wrwim_busy", 32'(op_ready), 0);
    chk("wrwim_early", wim, 0);
    tick();
    chk("wrwim_wim", wim, 32'h1);
    chk("wrwim_done", 32'(done), 1);
    chk("wrwim_ready", 32'(op_ready), 1);
    chk("wrwim_treq", 32'(trap_req), 0);
    tick();
    chk("wrwim_done_low", 32'(done), 0);

    // RETT commit from ET=0
    do_op(2'b10, 0);
    chk("rett_cwp", 32'(cwp), 1);
    chk("rett_et", 32'(et), 1);
    chk("rett_s", 32'(s), 0);
    chk("rett_done", 32'(done), 1);

    // SAVE overflow into window 0
    do_op(2'b00, 0);
    chk("ovf_treq", 32'(trap_req), 1);
    chk("ovf_tt", 32'(tt), 8'h05);
    chk("ovf_done", 32'(done), 0);
    chk("ovf_cwp", 32'(cwp), 1);
    tick(); tick(); tick();
    chk("ovf_hold", 32'(trap_req), 1);
    chk("ovf_ready", 32'(op_ready), 0);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("ack_cwp", 32'(cwp), 0);
    chk("ack_et", 32'(et), 0);
    chk("ack_s", 32'(s), 1);
    chk("ack_ps", 32'(ps), 0);
    chk("ack_done", 32'(done), 1);
    chk("ack_treq", 32'(trap_req), 0);
    chk("ack_ready", 32'(op_ready), 1);
    tick();

    // RESTORE commit with wrap 3 -> 0
    do_op(2'b11, 0);
    do_op(2'b01, 0);
    do_op(2'b01, 0);
    do_op(2'b01, 0);
    chk("walk_cwp", 32'(cwp), 3);
    do_op(2'b01, 0);
    chk("wrap_cwp", 32'(cwp), 0);
    chk("wrap_treq", 32'(trap_req), 0);
    chk("wrap_done", 32'(done), 1);

    // underflow with wrap: CWP=3, WIM=1, ET=1
    do_op(2'b10, 0);
    do_op(2'b01, 0);
    do_op(2'b01, 0);
    do_op(2'b11, 32'h1);
    chk("unf_pre_cwp", 32'(cwp), 3);
    chk("unf_pre_et", 32'(et), 1);
    do_op(2'b01, 0);
    chk("unf_treq", 32'(trap_req), 1);
    chk("unf_tt", 32'(tt), 8'h06);
    chk("unf_cwp", 32'(cwp), 3);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("unf_ack_cwp", 32'(cwp), 2);
    tick();

    // illegal RETT, then reset during TRAP
    do_op(2'b10, 0);
    chk("rett2_cwp", 32'(cwp), 3);
    chk("rett2_et", 32'(et), 1);
    do_op(2'b10, 0);
    chk("ill_treq", 32'(trap_req), 1);
    chk("ill_tt", 32'(tt), 8'h02);
    chk("ill_cwp", 32'(cwp), 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rtrap_treq", 32'(trap_req), 0);
    chk("rtrap_cwp", 32'(cwp), 0);
    chk("rtrap_wim", wim, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rtrap_done", 32'(done), 0);
    chk("rtrap_ready", 32'(op_ready), 1);

    // error mode: SAVE overflow with ET=0
    do_op(2'b11, 32'h8);
    do_op(2'b00, 0);
    chk("err_flag", 32'(error), 1);
    chk("err_ready", 32'(op_ready), 0);
    chk("err_treq", 32'(trap_req), 0);
    chk("err_done", 32'(done), 0);
    op_valid = 1'b1; op = 2'b01;
    tick(); tick(); tick();
    op_valid = 1'b0;
    chk("err_cwp", 32'(cwp), 0);
    chk("err_sticky", 32'(error), 1);
    chk("err_nodone", 32'(done), 0);
    reset_n = 1'b0;
    #1;
    chk("err_clr", 32'(error), 0);
    reset_n = 1'b1;
    tick();
    chk("err_ready2", 32'(op_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
